// File: rtl/display_arb_pkg.sv
// Shared types and widths for the seven-segment display arbiter.
// disp_data nibble n drives seg n; nibble 7 is bits 31:28, nibble 0 is bits 3:0.
package display_arb_pkg;

    localparam int unsigned NIB_W  = 4;
    localparam int unsigned NUM_NIB = 8;
    localparam int unsigned DISP_W = NUM_NIB * NIB_W;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHold = 2'd1,
        StOpen = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dwell_timer.sv
// Minimum-dwell timer: prescaler into a tick counter; a single-cycle expired pulse
// fires DWELL_TICKS*TICK_DIV cycles after the start edge, then idles until restarted.
module dwell_timer #(
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned DWELL_TICKS = 500
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic expired
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned TW = $clog2(DWELL_TICKS + 1);
    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(DWELL_TICKS - 1);

    logic [PW-1:0] r_pre;
    logic [TW-1:0] r_ticks;
    logic          r_run;
    logic          w_tick;

    assign w_tick  = (r_pre == PRE_MAX);
    // Decoded from registers so the FSM acts on the edge that completes the dwell.
    assign expired = r_run && w_tick && (r_ticks == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_ticks <= '0;
            r_run   <= 1'b0;
        end else if (start) begin
            r_pre   <= '0;
            r_ticks <= '0;
            r_run   <= 1'b1;
        end else if (r_run) begin
            if (expired) begin
                r_run <= 1'b0;
            end
            if (w_tick) begin
                r_pre   <= '0;
                r_ticks <= r_ticks + 1'b1;
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter with minimum dwell sharing the 8-digit display between requesters;
// the owner's value is tracked live while it keeps requesting and frozen once it lets go.
module display_arbiter
    import display_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned TICK_DIV    = 100000,
    parameter int unsigned DWELL_TICKS = 500
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DISP_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        grant,
    output logic [2:0]                owner,
    output logic [DISP_W-1:0]         disp_data,
    output logic                      disp_valid
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e          r_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       r_last;
    logic [DISP_W-1:0]   r_data;
    logic                r_valid;

    logic                w_expired;
    logic [NUM_REQ-1:0]  w_owner_oh;
    logic [NUM_REQ-1:0]  w_req_oth;
    logic                w_owner_live;
    logic [DISP_W-1:0]   w_live_data;
    logic                w_any;
    logic [IW-1:0]       w_any_idx;
    logic                w_oth;
    logic [IW-1:0]       w_oth_idx;
    logic                w_do_grant;
    logic [IW-1:0]       w_grant_idx;
    logic [DISP_W-1:0]   w_grant_data;

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] base, input int unsigned k);
        return IW'((32'(base) + k) % NUM_REQ);
    endfunction

    assign w_owner_oh   = NUM_REQ'(1) << r_owner;
    assign w_req_oth    = req & ~w_owner_oh;
    assign w_owner_live = req[r_owner];
    assign w_live_data  = data_in[32'(r_owner) * DISP_W +: DISP_W];

    // Search starts just after the last winner and wraps, so the previous owner comes last.
    always_comb begin
        w_any     = 1'b0;
        w_any_idx = '0;
        w_oth     = 1'b0;
        w_oth_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && req[rr_idx(r_last, k)]) begin
                w_any     = 1'b1;
                w_any_idx = rr_idx(r_last, k);
            end
            if (!w_oth && w_req_oth[rr_idx(r_last, k)]) begin
                w_oth     = 1'b1;
                w_oth_idx = rr_idx(r_last, k);
            end
        end
    end

    always_comb begin
        w_do_grant  = 1'b0;
        w_grant_idx = w_oth_idx;
        unique case (r_state)
            StIdle: begin
                w_do_grant  = w_any;
                w_grant_idx = w_any_idx;
            end
            StHold:  w_do_grant = w_expired && w_oth;
            StOpen:  w_do_grant = w_oth;
            default: w_do_grant = 1'b0;
        endcase
    end

    assign w_grant_data = data_in[32'(w_grant_idx) * DISP_W +: DISP_W];

    dwell_timer #(
        .TICK_DIV    (TICK_DIV),
        .DWELL_TICKS (DWELL_TICKS)
    ) u_dwell_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (w_do_grant),
        .expired (w_expired)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= StIdle;
            r_grant <= '0;
            r_owner <= '0;
            r_last  <= IW'(NUM_REQ - 1);
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_do_grant) begin
            // New grant replaces the old one on the same edge: no gap, never two-hot.
            r_state <= StHold;
            r_grant <= NUM_REQ'(1) << w_grant_idx;
            r_owner <= w_grant_idx;
            r_last  <= w_grant_idx;
            r_data  <= w_grant_data;
            r_valid <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    r_grant <= '0;
                    r_valid <= 1'b0;
                end
                StHold: begin
                    if (w_expired && !w_owner_live) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                    end else begin
                        if (w_expired) begin
                            r_state <= StOpen;
                        end
                        r_grant <= w_owner_live ? w_owner_oh : '0;
                        if (w_owner_live) begin
                            r_data <= w_live_data;
                        end
                    end
                end
                StOpen: begin
                    if (!w_owner_live) begin
                        r_state <= StIdle;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                    end else begin
                        r_data <= w_live_data;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign grant      = r_grant;
    assign owner      = 3'(r_owner);
    assign disp_data  = r_data;
    assign disp_valid = r_valid;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_REQ=4, TICK_DIV=4, DWELL_TICKS=3 (12-clk dwell).
module tb_display_arbiter;

    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'hBBBB_1111;
    localparam logic [31:0] D2 = 32'hCCCC_2222;
    localparam logic [31:0] D3 = 32'hDDDD_3333;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [3:0]   req = 4'b0000;
    logic [127:0] data_in = '0;
    logic [3:0]   grant;
    logic [2:0]   owner;
    logic [31:0]  disp_data;
    logic         disp_valid;

    int total = 0;
    int bad = 0;
    int twohot_cnt = 0;

    display_arbiter #(
        .NUM_REQ     (4),
        .TICK_DIV    (4),
        .DWELL_TICKS (3)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req        (req),
        .data_in    (data_in),
        .grant      (grant),
        .owner      (owner),
        .disp_data  (disp_data),
        .disp_valid (disp_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && !$onehot0(grant)) twohot_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_defaults();
        data_in = {D3, D2, D1, D0};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 4'b0000;
        load_defaults();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        load_defaults();
        #1 rst_n = 1'b0;
        #1;
        total++;
        if ({grant, owner, disp_data, disp_valid} !== 40'd0) begin
            bad++;
            $display("FAIL reset_init: got grant=%b owner=%0d data=%h valid=%b want all 0",
                     grant, owner, disp_data, disp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0001;
        tick();
        total++;
        if (grant !== 4'b0001 || owner !== 3'd0 || disp_data !== D0 || disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL first_grant: got grant=%b owner=%0d data=%h valid=%b want 0001/0/%h/1",
                     grant, owner, disp_data, disp_valid, D0);
        end
        data_in[31:0] = 32'h1234_5678;
        repeat (4) tick();
        total++;
        if (disp_data !== 32'h1234_5678) begin
            bad++;
            $display("FAIL hold_track: got data=%h want 12345678", disp_data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({grant, owner, disp_data, disp_valid} !== 40'd0) begin
            bad++;
            $display("FAIL async_reset: got grant=%b owner=%0d data=%h valid=%b want all 0",
                     grant, owner, disp_data, disp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (grant !== 4'b0001 || owner !== 3'd0 || disp_data !== 32'h1234_5678 ||
            disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL regrant_after_reset: got grant=%b owner=%0d data=%h valid=%b want 0001/0/12345678/1",
                     grant, owner, disp_data, disp_valid);
        end
    endtask

    task automatic test_round_robin();
        int err = 0;
        do_reset();
        req = 4'b0101;
        tick();
        total++;
        if (grant !== 4'b0001 || owner !== 3'd0 || disp_data !== D0 || disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL rr_first: got grant=%b owner=%0d data=%h valid=%b want 0001/0/%h/1",
                     grant, owner, disp_data, disp_valid, D0);
        end
        repeat (11) begin
            tick();
            if (grant !== 4'b0001) err++;
        end
        tick();
        total++;
        if (grant !== 4'b0100 || owner !== 3'd2 || disp_data !== D2 || err != 0) begin
            bad++;
            $display("FAIL rr_switch: got grant=%b owner=%0d data=%h early=%0d want 0100/2/%h/0",
                     grant, owner, disp_data, err, D2);
        end
        err = 0;
        repeat (11) begin
            tick();
            if (grant !== 4'b0100) err++;
        end
        tick();
        total++;
        if (grant !== 4'b0001 || owner !== 3'd0 || disp_data !== D0 || err != 0) begin
            bad++;
            $display("FAIL rr_back: got grant=%b owner=%0d data=%h early=%0d want 0001/0/%h/0",
                     grant, owner, disp_data, err, D0);
        end
    endtask

    task automatic test_live_open();
        int err = 0;
        do_reset();
        req = 4'b0001;
        data_in[31:0] = 32'h0000_1000;
        tick();
        total++;
        if (disp_data !== 32'h0000_1000 || grant !== 4'b0001) begin
            bad++;
            $display("FAIL live_start: got data=%h grant=%b want 00001000/0001", disp_data, grant);
        end
        for (int i = 1; i <= 14; i++) begin
            data_in[31:0] = 32'h0000_1000 + 32'(i);
            tick();
            if (disp_data !== 32'h0000_1000 + 32'(i) || grant !== 4'b0001) err++;
        end
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL live_track: got %0d lagging cycles want 0", err);
        end
        req = 4'b1001;
        tick();
        total++;
        if (grant !== 4'b1000 || owner !== 3'd3 || disp_data !== D3 || disp_valid !== 1'b1) begin
            bad++;
            $display("FAIL open_switch: got grant=%b owner=%0d data=%h valid=%b want 1000/3/%h/1",
                     grant, owner, disp_data, disp_valid, D3);
        end
    endtask

    task automatic test_short_pulse();
        int err = 0;
        do_reset();
        req = 4'b0001;
        data_in[31:0] = 32'h5555_0001;
        tick();
        data_in[31:0] = 32'h5555_0002;
        tick();
        req = 4'b0000;
        data_in[31:0] = 32'h5555_0003;
        tick();
        total++;
        if (grant !== 4'b0000 || disp_valid !== 1'b1 || disp_data !== 32'h5555_0002) begin
            bad++;
            $display("FAIL pulse_drop: got grant=%b valid=%b data=%h want 0000/1/55550002",
                     grant, disp_valid, disp_data);
        end
        repeat (9) begin
            tick();
            if (grant !== 4'b0000 || disp_valid !== 1'b1 || disp_data !== 32'h5555_0002) err++;
        end
        total++;
        if (err != 0) begin
            bad++;
            $display("FAIL pulse_dwell: got %0d bad cycles want 0", err);
        end
        tick();
        total++;
        if (grant !== 4'b0000 || disp_valid !== 1'b0 || disp_data !== 32'h5555_0002) begin
            bad++;
            $display("FAIL pulse_expire: got grant=%b valid=%b data=%h want 0000/0/55550002",
                     grant, disp_valid, disp_data);
        end
    endtask

    task automatic test_dwell_block();
        int err = 0;
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        tick();
        req = 4'b0011;
        repeat (9) begin
            tick();
            if (grant !== 4'b0001) err++;
        end
        tick();
        total++;
        if (grant !== 4'b0010 || owner !== 3'd1 || disp_data !== D1 || err != 0) begin
            bad++;
            $display("FAIL dwell_block: got grant=%b owner=%0d data=%h early=%0d want 0010/1/%h/0",
                     grant, owner, disp_data, err, D1);
        end
    endtask

    task automatic test_rotate();
        logic [3:0] rot_exp [0:4];
        logic [2:0] own_exp [0:4];
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        own_exp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        do_reset();
        req = 4'b1111;
        tick();
        total++;
        if (grant !== rot_exp[0] || owner !== own_exp[0]) begin
            bad++;
            $display("FAIL rotate_0: got grant=%b owner=%0d want %b/%0d",
                     grant, owner, rot_exp[0], own_exp[0]);
        end
        for (int g = 1; g <= 4; g++) begin
            int err = 0;
            repeat (11) begin
                tick();
                if (grant !== rot_exp[g-1]) err++;
            end
            tick();
            total++;
            if (grant !== rot_exp[g] || owner !== own_exp[g] || err != 0) begin
                bad++;
                $display("FAIL rotate_%0d: got grant=%b owner=%0d early=%0d want %b/%0d/0",
                         g, grant, owner, err, rot_exp[g], own_exp[g]);
            end
        end
    endtask

    task automatic test_never_two_hot();
        total++;
        if (twohot_cnt != 0) begin
            bad++;
            $display("FAIL never_two_hot: got %0d multi-hot cycles want 0", twohot_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_live_open();
        test_short_pulse();
        test_dwell_block();
        test_rotate();
        test_never_two_hot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
